// File: rtl/binary_to_bcd.sv
// -----------------------------------------------------------------------------
// binary_to_bcd
// Sequential shift-and-add-3 ("double dabble") converter. Converts an unsigned
// WIDTH-bit value into DIGITS packed BCD nibbles, one input bit per clock.
// Handshake: Start (accepted only in IDLE) -> Busy for WIDTH+1 cycles ->
// single-cycle Done with BCD/Overflow valid. Results hold until the next Done
// or Reset. Overflow flags values that need more than DIGITS digits; BCD then
// carries the value modulo 10^DIGITS.
// -----------------------------------------------------------------------------
module binary_to_bcd #(
   parameter int WIDTH  = 16,
   parameter int DIGITS = 5
) (
   input  logic                  Clk,
   input  logic                  Reset,
   input  logic                  Start,
   input  logic [WIDTH-1:0]      Binary,
   output logic                  Busy,
   output logic                  Done,
   output logic [4*DIGITS-1:0]   BCD,
   output logic                  Overflow
);

   localparam int CW = $clog2(WIDTH + 1);
   localparam int BW = 4 * DIGITS;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   state_t            r_state;
   state_t            w_next_state;

   logic [WIDTH-1:0]  r_shift;      // remaining input bits, MSB leaves first
   logic [BW-1:0]     r_digits;     // scratch BCD digits under construction
   logic              r_ovf;        // sticky: a 1 was shifted out of the top digit
   logic [CW-1:0]     r_count;      // shifts still to perform

   logic              r_busy;
   logic              r_done;
   logic [BW-1:0]     r_bcd;
   logic              r_overflow;

   logic [BW-1:0]     w_adjusted;   // scratch digits after the +3 correction
   logic [BW-1:0]     w_shifted;    // scratch digits after this cycle's shift
   logic              w_carry;      // bit leaving the top digit this cycle
   logic              w_last_shift;

   // State register.
   // NOTE: every clocked block uses non-blocking (<=) assignments so all flops
   // sample the pre-edge values; blocking here would create ordering races.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   assign w_last_shift = (r_count == CW'(1));

   // Next-state decode for the IDLE -> SHIFT -> DONE -> IDLE sequence.
   // NOTE: the default assignment before the case guarantees every path
   // assigns w_next_state, so no latch is inferred.
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_IDLE:  if (Start)        w_next_state = S_SHIFT;
         S_SHIFT: if (w_last_shift) w_next_state = S_DONE;
         S_DONE:                    w_next_state = S_IDLE;
         default:                   w_next_state = S_IDLE;
      endcase
   end

   // Add-3 correction: each digit that is 5 or more gets +3 so that the
   // following doubling carries correctly into the next decimal digit.
   always_comb begin
      w_adjusted = r_digits;
      for (int i = 0; i < DIGITS; i++) begin
         if (r_digits[4*i +: 4] >= 4'd5) begin
            w_adjusted[4*i +: 4] = r_digits[4*i +: 4] + 4'd3;
         end
      end
   end

   // Shift {digits, shift register} left by one; the top digit's bit 3 is the
   // decimal carry out of the result, which is counted as overflow.
   assign w_carry   = w_adjusted[BW-1];
   assign w_shifted = {w_adjusted[BW-2:0], r_shift[WIDTH-1]};

   // Datapath and registered outputs. Busy/Done are registered copies of the
   // state being entered so they line up exactly with the state register.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         r_shift    <= '0;
         r_digits   <= '0;
         r_ovf      <= 1'b0;
         r_count    <= '0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_bcd      <= '0;
         r_overflow <= 1'b0;
      end else begin
         r_busy <= (w_next_state != S_IDLE);
         r_done <= (w_next_state == S_DONE);
         case (r_state)
            S_IDLE: begin
               if (Start) begin
                  r_shift  <= Binary;
                  r_digits <= '0;
                  r_ovf    <= 1'b0;
                  r_count  <= CW'(WIDTH);
               end
            end
            S_SHIFT: begin
               r_shift  <= r_shift << 1;
               r_digits <= w_shifted;
               r_ovf    <= r_ovf | w_carry;
               r_count  <= r_count - CW'(1);
               // Publish only the final result; intermediate values stay internal.
               if (w_last_shift) begin
                  r_bcd      <= w_shifted;
                  r_overflow <= r_ovf | w_carry;
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign Busy     = r_busy;
   assign Done     = r_done;
   assign BCD      = r_bcd;
   assign Overflow = r_overflow;

endmodule

// File: tb/tb_binary_to_bcd.sv
// -----------------------------------------------------------------------------
// tb_binary_to_bcd
// Scoreboard bench for two instances: the default 16-bit/5-digit converter and
// an 8-bit/2-digit one. Stimulus pushes the expected BCD, overflow and Done
// cycle into a queue; per-instance monitors pop and compare on every Done.
// -----------------------------------------------------------------------------
module tb_binary_to_bcd;

   typedef struct {
      logic [19:0] bcd;
      logic        ovf;
      int          cyc;
   } exp_t;

   logic        Clk = 1'b0;
   logic        Reset = 1'b1;

   logic        start16 = 1'b0;
   logic [15:0] bin16 = '0;
   logic        busy16, done16, ovf16;
   logic [19:0] bcd16;

   logic        start8 = 1'b0;
   logic [7:0]  bin8 = '0;
   logic        busy8, done8, ovf8;
   logic [7:0]  bcd8;

   int errors = 0;
   int checks = 0;
   int cyc    = 0;

   exp_t q16[$];
   exp_t q8[$];

   binary_to_bcd dut16 (
      .Clk      (Clk),
      .Reset    (Reset),
      .Start    (start16),
      .Binary   (bin16),
      .Busy     (busy16),
      .Done     (done16),
      .BCD      (bcd16),
      .Overflow (ovf16)
   );

   binary_to_bcd #(.WIDTH(8), .DIGITS(2)) dut8 (
      .Clk      (Clk),
      .Reset    (Reset),
      .Start    (start8),
      .Binary   (bin8),
      .Busy     (busy8),
      .Done     (done8),
      .BCD      (bcd8),
      .Overflow (ovf8)
   );

   always #5 Clk = ~Clk;

   // Cycle index: value after rising edge k is k.
   always @(posedge Clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Monitor for the 16-bit instance.
   always @(negedge Clk) begin : mon16
      exp_t e;
      if (done16) begin
         if (q16.size() == 0) begin
            check("dut16 Done with nothing expected", {31'd0, done16}, 32'd0);
         end else begin
            e = q16.pop_front();
            check("dut16 BCD", {12'd0, bcd16}, {12'd0, e.bcd});
            check("dut16 Overflow", {31'd0, ovf16}, {31'd0, e.ovf});
            check("dut16 Done cycle", cyc, e.cyc);
            check("dut16 Busy during Done", {31'd0, busy16}, 32'd1);
         end
      end
   end

   // Monitor for the 8-bit instance.
   always @(negedge Clk) begin : mon8
      exp_t e;
      if (done8) begin
         if (q8.size() == 0) begin
            check("dut8 Done with nothing expected", {31'd0, done8}, 32'd0);
         end else begin
            e = q8.pop_front();
            check("dut8 BCD", {24'd0, bcd8}, {12'd0, e.bcd});
            check("dut8 Overflow", {31'd0, ovf8}, {31'd0, e.ovf});
            check("dut8 Done cycle", cyc, e.cyc);
         end
      end
   end

   // Pulse Start for one cycle; the accepting edge index is read #1 after it.
   task automatic go16(input logic [15:0] v, input logic [19:0] exp_bcd, input logic exp_ovf);
      exp_t e;
      @(posedge Clk); #1;
      bin16   = v;
      start16 = 1'b1;
      @(posedge Clk); #1;
      start16 = 1'b0;
      e.bcd = exp_bcd;
      e.ovf = exp_ovf;
      e.cyc = cyc + 16;
      q16.push_back(e);
   endtask

   task automatic go8(input logic [7:0] v, input logic [7:0] exp_bcd, input logic exp_ovf);
      exp_t e;
      @(posedge Clk); #1;
      bin8   = v;
      start8 = 1'b1;
      @(posedge Clk); #1;
      start8 = 1'b0;
      e.bcd = {12'd0, exp_bcd};
      e.ovf = exp_ovf;
      e.cyc = cyc + 8;
      q8.push_back(e);
   endtask

   task automatic wait_idle16();
      int n = 0;
      @(negedge Clk);
      while (busy16 && n < 60) begin
         @(negedge Clk);
         n++;
      end
      check("dut16 returns to idle", {31'd0, busy16}, 32'd0);
   endtask

   task automatic wait_idle8();
      int n = 0;
      @(negedge Clk);
      while (busy8 && n < 60) begin
         @(negedge Clk);
         n++;
      end
      check("dut8 returns to idle", {31'd0, busy8}, 32'd0);
   endtask

   initial begin
      int   busy_cnt;
      int   acc;
      exp_t e;

      // Reset state.
      repeat (3) @(posedge Clk);
      #1 Reset = 1'b0;
      @(negedge Clk);
      check("reset Busy", {31'd0, busy16}, 32'd0);
      check("reset Done", {31'd0, done16}, 32'd0);
      check("reset BCD", {12'd0, bcd16}, 32'd0);
      check("reset Overflow", {31'd0, ovf16}, 32'd0);

      // Zero input; Busy must last exactly WIDTH+1 = 17 cycles.
      go16(16'd0, 20'h00000, 1'b0);
      busy_cnt = 0;
      repeat (25) begin
         @(negedge Clk);
         if (busy16) busy_cnt++;
      end
      check("dut16 Busy length", busy_cnt, 32'd17);

      // Directed values including the full-scale input.
      go16(16'd65535, 20'h65535, 1'b0); wait_idle16();
      go16(16'd9,     20'h00009, 1'b0); wait_idle16();
      go16(16'd10,    20'h00010, 1'b0); wait_idle16();
      go16(16'd1000,  20'h01000, 1'b0); wait_idle16();

      // Input change and Start during SHIFT are ignored.
      go16(16'd1234, 20'h01234, 1'b0);
      repeat (3) @(posedge Clk);
      #1 bin16 = 16'd4321;
      start16 = 1'b1;
      @(posedge Clk); #1 start16 = 1'b0;
      wait_idle16();
      repeat (20) @(negedge Clk);

      // Start held high: one accepted conversion every 18 cycles.
      @(posedge Clk); #1;
      bin16   = 16'd42;
      start16 = 1'b1;
      acc     = cyc + 1;
      for (int k = 0; k < 3; k++) begin
         e.bcd = 20'h00042;
         e.ovf = 1'b0;
         e.cyc = acc + 18 * k + 16;
         q16.push_back(e);
      end
      repeat (40) @(posedge Clk);
      #1 start16 = 1'b0;
      wait_idle16();
      check("dut16 BCD holds after Done", {12'd0, bcd16}, 32'h00042);

      // Reset five cycles into converting 999 abandons the conversion.
      @(posedge Clk); #1;
      bin16   = 16'd999;
      start16 = 1'b1;
      @(posedge Clk); #1 start16 = 1'b0;
      repeat (4) @(posedge Clk);
      #1 Reset = 1'b1;
      @(posedge Clk); #1 Reset = 1'b0;
      @(negedge Clk);
      check("mid-conversion reset Busy", {31'd0, busy16}, 32'd0);
      check("mid-conversion reset Done", {31'd0, done16}, 32'd0);
      check("mid-conversion reset BCD", {12'd0, bcd16}, 32'd0);
      repeat (30) @(negedge Clk);
      go16(16'd7, 20'h00007, 1'b0); wait_idle16();

      // Narrow instance: in-range maximum and overflow cases.
      go8(8'd99,  8'h99, 1'b0); wait_idle8();
      go8(8'd255, 8'h55, 1'b1); wait_idle8();
      check("dut8 Overflow holds after Done", {31'd0, ovf8}, 32'd1);
      go8(8'd100, 8'h00, 1'b1); wait_idle8();
      go8(8'd37,  8'h37, 1'b0); wait_idle8();

      repeat (5) @(negedge Clk);
      check("dut16 outstanding results", q16.size(), 32'd0);
      check("dut8 outstanding results", q8.size(), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
